pattern_sweep_capture: RTL and testbench
========================================

PATTERN_SWEEP_CAPTURE -- requirements
Module: pattern_sweep_capture

Interface
REQ-001 SHALL provide parameter N_WIDTH, default 2, width of the stimulus vector driven into the design under test.
REQ-002 SHALL provide parameter HOLD, default 1, minimum 1, the number of cycles each pattern is applied before sampling.
REQ-003 SHALL provide parameter SIG_WIDTH, default 16, the width of the response signature register.
REQ-004 SHALL use one clock and a synchronous, active-high reset (fixed decision).
REQ-005 CK  input  1  clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
REQ-008 dut_out  input  1  single-bit response from the design under test.
REQ-009 N  output  N_WIDTH  stimulus vector to the design under test.
REQ-010 busy  output  1  high in APPLY, SAMPLE and EMIT.
REQ-011 rec_valid  output  1  a pattern/response record is offered downstream.
REQ-012 rec_ready  input  1  downstream logger accepts the record.
REQ-013 rec_pattern  output  N_WIDTH  pattern of the offered record.
REQ-014 rec_response  output  1  captured dut_out for that pattern.
REQ-015 done  output  1  sweep complete; held until the next start or reset.
REQ-016 signature  output  SIG_WIDTH  running response signature.

Function
REQ-017 SHALL implement states IDLE, APPLY, SAMPLE, EMIT and DONE.
REQ-018 IDLE: N=0 and busy=0; start=1 -> APPLY with pattern=0, hold count=0 and signature cleared to 0.
REQ-019 APPLY: N=pattern; the hold counter increments each cycle; on the cycle with count==HOLD-1 -> SAMPLE.
REQ-020 SAMPLE: SHALL register dut_out into rec_response and pattern into rec_pattern on the exiting edge, update the signature, then -> EMIT.
REQ-021 Signature update SHALL be: shift left by 1; if the old MSB was 1, XOR with 0x1021 (truncated to SIG_WIDTH); then XOR bit 0 with the sampled dut_out.
REQ-022 EMIT: rec_valid=1 with rec_pattern and rec_response held stable until rec_valid and rec_ready are both high on a rising edge.
REQ-023 On an EMIT handshake: if pattern is all ones -> DONE, else pattern+1 and -> APPLY with hold count=0.
REQ-024 N SHALL stay constant across APPLY, SAMPLE and EMIT of one pattern and change only on entry to the next APPLY.
REQ-025 With rec_ready tied high, each pattern SHALL take exactly HOLD+2 cycles; a full sweep SHALL take 2^N_WIDTH*(HOLD+2) cycles from the first APPLY cycle to DONE entry.
REQ-026 The pattern counter SHALL never wrap; the all-ones check precedes any increment.
REQ-027 DONE: done=1, busy=0, rec_valid=0, N=0, signature frozen; start=1 -> APPLY as in REQ-018, with done cleared.
REQ-028 start while busy SHALL be ignored, with no effect on state, pattern or signature.
REQ-029 rec_ready while not in EMIT SHALL have no effect.

Reset
REQ-030 reset=1 SHALL force, on the next edge, state=IDLE, N=0, pattern=0, hold count=0, busy=0, rec_valid=0, rec_pattern=0, rec_response=0, done=0 and signature=0.
REQ-031 reset SHALL take priority over start, rec_ready and every state transition, including mid-sweep and mid-handshake; an offered record is dropped.

Verification
REQ-032 N_WIDTH=2, HOLD=1, rec_ready=1, dut_out=N[0]^N[1], start pulse -> records (00,0) (01,1) (10,1) (11,0) in order; done after 12 cycles; signature=0x0006.
REQ-033 Same setup, dut_out=1 constantly -> all four rec_response=1; signature=0x000F.
REQ-034 rec_ready held low for 5 cycles in the EMIT of pattern 01 -> rec_valid, rec_pattern=01 and N=01 stay stable for all 5 cycles; no signature change; the sweep resumes after the handshake.
REQ-035 start pulsed while in APPLY of pattern 10 -> ignored; exactly four records are produced and the final signature is unchanged.
REQ-036 reset asserted in SAMPLE of pattern 10 -> next cycle all outputs are 0 and the state is IDLE; a new start produces a full sweep beginning at pattern 00.
REQ-037 HOLD=3 -> N is stable for 3 APPLY cycles per pattern; a sweep with N_WIDTH=2 and ready=1 takes 20 cycles.

Source files
------------

// File: rtl/pattern_sweep_capture.sv
// ----------------------------------------------------------------------------
// pattern_sweep_capture : sweeps every N_WIDTH-bit stimulus pattern, captures
// the single-bit response of each, logs it downstream and folds it into a CRC.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pattern_sweep_capture #(
    parameter int N_WIDTH   = 2,
    parameter int HOLD      = 1,
    parameter int SIG_WIDTH = 16
) (
    input  logic                 CK,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 dut_out,
    output logic [N_WIDTH-1:0]   N,
    output logic                 busy,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [N_WIDTH-1:0]   rec_pattern,
    output logic                 rec_response,
    output logic                 done,
    output logic [SIG_WIDTH-1:0] signature
);

    localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HC_W-1:0]      HOLD_LAST = HC_W'(HOLD - 1);
    localparam logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(32'h1021);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_APPLY  = 3'd1;
    localparam logic [2:0] S_SAMPLE = 3'd2;
    localparam logic [2:0] S_EMIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]           state_q,        state_d;
    logic [N_WIDTH-1:0]   pattern_q,      pattern_d;
    logic [HC_W-1:0]      hold_q,         hold_d;
    logic [SIG_WIDTH-1:0] sig_q,          sig_d;
    logic [N_WIDTH-1:0]   rec_pattern_q,  rec_pattern_d;
    logic                 rec_response_q, rec_response_d;
    logic [SIG_WIDTH-1:0] sig_next;

    // Feedback taken from the MSB before the shift, response folded into bit 0.
    always_comb begin
        sig_next    = (sig_q << 1) ^ (sig_q[SIG_WIDTH-1] ? POLY : '0);
        sig_next[0] = sig_next[0] ^ dut_out;
    end

    always_comb begin
        state_d        = state_q;
        pattern_d      = pattern_q;
        hold_d         = hold_q;
        sig_d          = sig_q;
        rec_pattern_d  = rec_pattern_q;
        rec_response_d = rec_response_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_APPLY;
                    pattern_d = '0;
                    hold_d    = '0;
                    sig_d     = '0;
                end
            end
            S_APPLY: begin
                hold_d = hold_q + HC_W'(1);
                if (hold_q == HOLD_LAST) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                rec_pattern_d  = pattern_q;
                rec_response_d = dut_out;
                sig_d          = sig_next;
                state_d        = S_EMIT;
            end
            S_EMIT: begin
                // All-ones test comes first so the pattern counter never wraps.
                if (rec_ready) begin
                    if (&pattern_q) begin
                        state_d = S_DONE;
                    end else begin
                        pattern_d = pattern_q + N_WIDTH'(1);
                        hold_d    = '0;
                        state_d   = S_APPLY;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            state_q        <= S_IDLE;
            pattern_q      <= '0;
            hold_q         <= '0;
            sig_q          <= '0;
            rec_pattern_q  <= '0;
            rec_response_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pattern_q      <= pattern_d;
            hold_q         <= hold_d;
            sig_q          <= sig_d;
            rec_pattern_q  <= rec_pattern_d;
            rec_response_q <= rec_response_d;
        end
    end

    always_comb begin
        busy         = (state_q == S_APPLY) || (state_q == S_SAMPLE) || (state_q == S_EMIT);
        N            = busy ? pattern_q : '0;
        rec_valid    = (state_q == S_EMIT);
        done         = (state_q == S_DONE);
        rec_pattern  = rec_pattern_q;
        rec_response = rec_response_q;
        signature    = sig_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_pattern_sweep_capture.sv
// ----------------------------------------------------------------------------
// tb_pattern_sweep_capture : bench for pattern_sweep_capture (HOLD=1 and HOLD=3).
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pattern_sweep_capture;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic        reset;
    int          checks = 0;
    int          errors = 0;

    // Instance A: N_WIDTH=2, HOLD=1, SIG_WIDTH=16
    logic        start_a, ready_a, busy_a, rv_a, rr_a, done_a, dut_out_a;
    logic [1:0]  N_a, rp_a;
    logic [15:0] sig_a;
    logic [3:0]  tbl_a;
    assign dut_out_a = tbl_a[N_a];

    // Instance B: N_WIDTH=2, HOLD=3, SIG_WIDTH=3 (narrow so feedback truncation matters)
    logic        start_b, ready_b, busy_b, rv_b, rr_b, done_b, dut_out_b;
    logic [1:0]  N_b, rp_b;
    logic [2:0]  sig_b;
    logic [3:0]  tbl_b;
    assign dut_out_b = tbl_b[N_b];

    pattern_sweep_capture #(.N_WIDTH(2), .HOLD(1), .SIG_WIDTH(16)) u_a (
        .CK(CK), .reset(reset), .start(start_a), .dut_out(dut_out_a), .N(N_a),
        .busy(busy_a), .rec_valid(rv_a), .rec_ready(ready_a), .rec_pattern(rp_a),
        .rec_response(rr_a), .done(done_a), .signature(sig_a));

    pattern_sweep_capture #(.N_WIDTH(2), .HOLD(3), .SIG_WIDTH(3)) u_b (
        .CK(CK), .reset(reset), .start(start_b), .dut_out(dut_out_b), .N(N_b),
        .busy(busy_b), .rec_valid(rv_b), .rec_ready(ready_b), .rec_pattern(rp_b),
        .rec_response(rr_b), .done(done_b), .signature(sig_b));

    // Reference signature: CRC-style fold of the responses in pattern order.
    function automatic logic [15:0] sig_ref(input int w, input logic [3:0] tbl);
        logic [15:0] s;
        logic [15:0] mask;
        logic        msb;
        s    = '0;
        mask = 16'hFFFF >> (16 - w);
        for (int p = 0; p < 4; p++) begin
            msb = s[w-1];
            s   = ((s << 1) ^ (msb ? 16'h1021 : 16'h0000)) & mask;
            s   = s ^ {15'b0, tbl[p]};
        end
        return s;
    endfunction

    // Observations gathered by sweep_a (measurement only, no pass/fail decisions).
    int         obs_done, n_recs, n_bad, stall_bad, rst_seen;
    logic [1:0] got_p [8];
    logic       got_r [8];

    task automatic sweep_a(input int stall_pat, input int stall_len,
                           input int start_pat, input int reset_pat);
        int         stalled;
        int         pc;
        bit         injected;
        logic [1:0] hp;
        logic [15:0] hs;
        stalled = 0; pc = 0; injected = 0; hp = '0; hs = '0;
        obs_done = 0; n_recs = 0; n_bad = 0; stall_bad = 0; rst_seen = 0;
        ready_a = 1'b1;
        @(negedge CK) start_a = 1'b1;
        @(negedge CK) start_a = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            start_a = 1'b0;
            if (done_a) begin
                obs_done = c;
                break;
            end
            if (!busy_a || N_a !== n_recs[1:0]) n_bad++;
            if (reset_pat == n_recs && pc == 1) begin
                reset = 1'b1;
                @(negedge CK);
                reset    = 1'b0;
                rst_seen = 1;
                return;
            end
            if (start_pat == n_recs && pc == 0 && !injected) begin
                start_a  = 1'b1;
                injected = 1;
            end
            ready_a = 1'b1;
            if (rv_a) begin
                if (stall_pat == n_recs && stalled < stall_len) begin
                    ready_a = 1'b0;
                    if (stalled == 0) begin
                        hp = rp_a;
                        hs = sig_a;
                    end else if (rp_a !== hp || sig_a !== hs || N_a !== hp) begin
                        stall_bad++;
                    end
                    stalled++;
                end else begin
                    if (n_recs < 8) begin
                        got_p[n_recs] = rp_a;
                        got_r[n_recs] = rr_a;
                    end
                    n_recs++;
                    pc = -1;
                end
            end
            pc++;
            @(negedge CK);
        end
        ready_a = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge CK);
        checks++;
        if ({N_a, busy_a, rv_a, rp_a, rr_a, done_a, sig_a} !== '0) begin
            errors++;
            $display("FAIL reset_a outputs got %h want 0", {N_a, busy_a, rv_a, rp_a, rr_a, done_a, sig_a});
        end
        checks++;
        if ({N_b, busy_b, rv_b, rp_b, rr_b, done_b, sig_b} !== '0) begin
            errors++;
            $display("FAIL reset_b outputs got %h want 0", {N_b, busy_b, rv_b, rp_b, rr_b, done_b, sig_b});
        end
        reset = 1'b0;
        @(negedge CK);
    endtask

    task automatic test_sweep(input string name, input logic [3:0] tbl,
                              input int stall_pat, input int stall_len, input int start_pat);
        logic [15:0] esig;
        tbl_a = tbl;
        esig  = sig_ref(16, tbl);
        sweep_a(stall_pat, stall_len, start_pat, -1);
        checks++;
        if (obs_done !== 13 + stall_len) begin
            errors++;
            $display("FAIL %s done_cycle got %0d want %0d", name, obs_done - 1, 12 + stall_len);
        end
        checks++;
        if (n_recs !== 4 || n_bad !== 0 || stall_bad !== 0) begin
            errors++;
            $display("FAIL %s records got n=%0d nbad=%0d stallbad=%0d want 4/0/0", name, n_recs, n_bad, stall_bad);
        end
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (p >= n_recs || got_p[p] !== p[1:0] || got_r[p] !== tbl[p]) begin
                errors++;
                $display("FAIL %s rec%0d got (%b,%b) want (%b,%b)", name, p, got_p[p], got_r[p], p[1:0], tbl[p]);
            end
        end
        checks++;
        if (sig_a !== esig) begin
            errors++;
            $display("FAIL %s signature got %h want %h", name, sig_a, esig);
        end
        repeat (3) begin
            @(negedge CK);
            checks++;
            if (!done_a || busy_a || rv_a || N_a !== 2'b00 || sig_a !== esig) begin
                errors++;
                $display("FAIL %s done_hold got done=%b busy=%b rv=%b N=%b sig=%h", name, done_a, busy_a, rv_a, N_a, sig_a);
            end
        end
    endtask

    task automatic test_fixed_signatures;
        test_sweep("xor", 4'b0110, -1, 0, -1);
        checks++;
        if (sig_a !== 16'h0006) begin
            errors++;
            $display("FAIL xor_sig_const got %h want 0006", sig_a);
        end
        test_sweep("ones", 4'b1111, -1, 0, -1);
        checks++;
        if (sig_a !== 16'h000F) begin
            errors++;
            $display("FAIL ones_sig_const got %h want 000f", sig_a);
        end
    endtask

    task automatic test_stall;
        test_sweep("stall", 4'($urandom), 1, 5, -1);
    endtask

    task automatic test_start_ignored;
        test_sweep("start_busy", 4'b0110, -1, 0, 2);
    endtask

    task automatic test_reset_mid;
        tbl_a = 4'b0110;
        sweep_a(-1, 0, -1, 2);
        checks++;
        if (rst_seen !== 1 || {N_a, busy_a, rv_a, rp_a, rr_a, done_a, sig_a} !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs got seen=%0d %h want 1/0", rst_seen, {N_a, busy_a, rv_a, rp_a, rr_a, done_a, sig_a});
        end
        test_sweep("after_reset", 4'b0110, -1, 0, -1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 4; i++) begin
            test_sweep("random", 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), -1);
        end
    endtask

    task automatic test_hold3;
        logic [3:0] tbls [2];
        int         cnt [4];
        int         nrec;
        int         done_obs;
        int         bad;
        logic [15:0] esig;
        tbls[0] = 4'b1111;
        tbls[1] = 4'($urandom);
        for (int k = 0; k < 2; k++) begin
            tbl_b = tbls[k];
            esig  = sig_ref(3, tbls[k]);
            for (int p = 0; p < 4; p++) cnt[p] = 0;
            nrec = 0; done_obs = 0; bad = 0;
            @(negedge CK) start_b = 1'b1;
            @(negedge CK) start_b = 1'b0;
            for (int c = 1; c <= 100; c++) begin
                if (done_b) begin
                    done_obs = c;
                    break;
                end
                if (busy_b) cnt[N_b]++;
                if (rv_b) begin
                    if (rp_b !== nrec[1:0] || rr_b !== tbls[k][nrec[1:0]]) bad++;
                    nrec++;
                end
                @(negedge CK);
            end
            checks++;
            if (done_obs !== 21) begin
                errors++;
                $display("FAIL hold3 done_cycle got %0d want 20", done_obs - 1);
            end
            checks++;
            if (cnt[0] !== 5 || cnt[1] !== 5 || cnt[2] !== 5 || cnt[3] !== 5) begin
                errors++;
                $display("FAIL hold3 per_pattern got %0d %0d %0d %0d want 5 each", cnt[0], cnt[1], cnt[2], cnt[3]);
            end
            checks++;
            if (nrec !== 4 || bad !== 0) begin
                errors++;
                $display("FAIL hold3 records got n=%0d bad=%0d want 4/0", nrec, bad);
            end
            checks++;
            if (sig_b !== esig[2:0]) begin
                errors++;
                $display("FAIL hold3 signature got %h want %h", sig_b, esig[2:0]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start_a = 1'b0; ready_a = 1'b1; tbl_a = 4'b0110;
        start_b = 1'b0; ready_b = 1'b1; tbl_b = 4'b1111;
        test_reset();
        test_fixed_signatures();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_random();
        test_hold3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
